// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states and port indices.
// Build option DMEM_ARB_RR_EN selects round-robin tie breaking in IDLE.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK1 = 2'd1,
        ST_BREAK = 2'd2
    } arb_state_e;

    typedef logic port_idx_t;

    localparam port_idx_t PORT_CORE = 1'b0;
    localparam port_idx_t PORT_LDR  = 1'b1;

    // Tie goes to the port that was not granted last.
    function automatic port_idx_t tie_winner(input port_idx_t last);
        return (last == PORT_CORE) ? PORT_LDR : PORT_CORE;
    endfunction

endpackage

// File: rtl/dmem_arb_rsp.sv
// Per-port read response register for dmem_arbiter.
// Captures readdata on a granted load, pulses rvalid for one cycle.
module dmem_arb_rsp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_i,
    input  logic [31:0] rdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    logic        rvalid_q;
    logic [31:0] rdata_q;

    // Load data is held until the next granted load on this port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= cap_i;
            if (cap_i) begin
                rdata_q <= rdata_i;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master dmem arbiter (core = m0, loader = m1) with m1 lock bursts.
// Define DMEM_ARB_RR_EN for round-robin ties in IDLE; default is m0 priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = 8,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [2:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [2:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_lock,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_stall,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          memwrite,
    output logic [2:0]    memsize,
    output logic [AW-1:0] dataadr,
    output logic [31:0]   writedata,
    input  logic [31:0]   readdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          gnt0, gnt1;

`ifdef DMEM_ARB_RR_EN
    port_idx_t last_q, last_d;
`endif

    // Grant selection and lock FSM next state.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cnt_inc    = (lock_cnt_q == CNT_MAX) ? CNT_MAX
                                             : lock_cnt_q + CNT_ONE;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
                    gnt1 = (tie_winner(last_q) == PORT_LDR);
`else
                    gnt1 = 1'b0;
`endif
                    gnt0 = ~gnt1;
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
                if (gnt1 && m1_lock) begin
                    state_d    = ST_LOCK1;
                    lock_cnt_d = CNT_ONE;
                end
            end
            ST_LOCK1: begin
                gnt1 = m1_req;
                gnt0 = m0_req & ~m1_req;
                if (!(m1_req && m1_lock)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX && m0_req) begin
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                gnt0 = m0_req;
                gnt1 = m1_req & ~m0_req;
                if (m1_req && m1_lock) begin
                    state_d    = ST_LOCK1;
                    lock_cnt_d = gnt1 ? CNT_ONE : '0;
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // FSM state and lock counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember the most recent grant for round-robin ties.
    always_comb begin
        last_d = last_q;
        if (gnt1) begin
            last_d = PORT_LDR;
        end else if (gnt0) begin
            last_d = PORT_CORE;
        end
    end

    // Last-granted port register; m0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= PORT_LDR;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_stall  = m0_req & ~gnt0;
    assign memwrite  = (gnt0 & m0_we) | (gnt1 & m1_we);
    assign memsize   = gnt1 ? m1_size  : m0_size;
    assign dataadr   = gnt1 ? m1_addr  : m0_addr;
    assign writedata = gnt1 ? m1_wdata : m0_wdata;

    dmem_arb_rsp u_rsp0 (
        .clk      (clk),
        .rst_n    (reset),
        .cap_i    (gnt0 & ~m0_we),
        .rdata_i  (readdata),
        .rvalid_o (m0_rvalid),
        .rdata_o  (m0_rdata)
    );

    dmem_arb_rsp u_rsp1 (
        .clk      (clk),
        .rst_n    (reset),
        .cap_i    (gnt1 & ~m1_we),
        .rdata_i  (readdata),
        .rvalid_o (m1_rvalid),
        .rdata_o  (m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-addressed dmem model.
// Expectations follow DMEM_ARB_RR_EN when the tie sequence is checked.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [2:0]    m0_size, m1_size;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_stall;
    logic          m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          memwrite;
    logic [2:0]    memsize;
    logic [AW-1:0] dataadr;
    logic [31:0]   writedata, readdata;

    logic [31:0]   mem [0:1023];

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    assign readdata = mem[dataadr[11:2]];

    // dmem model: store commits on the rising edge ending the grant.
    always @(posedge clk) begin
        if (memwrite) mem[dataadr[11:2]] <= writedata;
    end

    dmem_arbiter #(.MAX_LOCK(8), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_size   (m0_size),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_size   (m1_size),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_stall  (m0_stall),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .memwrite  (memwrite),
        .memsize   (memsize),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_size = 3'b010;
        m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_size = 3'b010;
        m1_addr = '0; m1_wdata = '0; m1_lock = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic e0;
        logic [31:0] idx;
        logic [5:0] d_m1, d_m0r, d_lk;

        reset = 1'b0;
        idle();
        for (int i = 0; i < 1024; i++) mem[i] <= '0;
        mem[10'h040] <= 32'hDEADBEEF;

        // Requests during reset get no grant and no write.
        m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'h1;
        @(negedge clk); #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_memwrite", memwrite, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        @(negedge clk);
        chk("rst_mem_kept", mem[10'h040], 32'hDEADBEEF);
        reset = 1'b1;
        idle();

        // Lone m0 load of 0x100.
        m0_req = 1; m0_addr = 32'h100;
        #1;
        chk("ld_m0_gnt", m0_gnt, 1);
        chk("ld_m1_gnt", m1_gnt, 0);
        chk("ld_stall", m0_stall, 0);
        chk("ld_memwrite", memwrite, 0);
        chk("ld_dataadr", dataadr, 32'h100);
        @(negedge clk);
        chk("ld_rvalid", m0_rvalid, 1);
        chk("ld_rdata", m0_rdata, 32'hDEADBEEF);
        chk("ld_m1_rvalid", m1_rvalid, 0);
        idle();
        @(negedge clk);
        chk("ld_rvalid_pulse", m0_rvalid, 0);

        // m1 SW 0x12345678 to 0x200, then m0 LW 0x200.
        m1_req = 1; m1_we = 1; m1_addr = 32'h200;
        m1_wdata = 32'h12345678;
        #1;
        chk("st_m1_gnt", m1_gnt, 1);
        chk("st_memwrite", memwrite, 1);
        chk("st_dataadr", dataadr, 32'h200);
        chk("st_wdata", writedata, 32'h12345678);
        chk("st_memsize", memsize, 3'b010);
        @(negedge clk);
        chk("st_no_rvalid", m1_rvalid, 0);
        chk("st_mem", mem[10'h080], 32'h12345678);
        idle();
        m0_req = 1; m0_addr = 32'h200;
        #1;
        chk("rb_m0_gnt", m0_gnt, 1);
        @(negedge clk);
        chk("rb_rvalid", m0_rvalid, 1);
        chk("rb_rdata", m0_rdata, 32'h12345678);
        idle();

        // Both request loads every cycle, no lock.
        m0_req = 1; m0_addr = 32'h100;
        m1_req = 1; m1_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            e0 = (k % 2) == 1;
`else
            e0 = 1'b1;
`endif
            #1;
            chk("tie_m0_gnt", m0_gnt, e0);
            chk("tie_m1_gnt", m1_gnt, !e0);
            chk("tie_stall", m0_stall, !e0);
            @(negedge clk);
            chk("tie_m0_rvalid", m0_rvalid, e0);
            chk("tie_m1_rvalid", m1_rvalid, !e0);
        end
        chk("tie_m0_rdata", m0_rdata, 32'hDEADBEEF);
        idle();

        // Locked 20-store burst; m0 loads from cycle 2.
        for (int c = 0; c < 21; c++) begin
            idx = (c < 8) ? 32'(c) : 32'(c - 1);
            m1_req = 1; m1_lock = 1; m1_we = 1;
            m1_addr = 32'h300 + 4 * idx;
            m1_wdata = idx;
            m0_req = (c >= 2 && c <= 8);
            m0_addr = 32'h100;
            #1;
            chk("lk_m1_gnt", m1_gnt, c != 8);
            chk("lk_m0_gnt", m0_gnt, c == 8);
            @(negedge clk);
            chk("lk_m0_rvalid", m0_rvalid, c == 8);
        end
        idle();
        chk("lk_mem7", mem[10'h0C7], 32'd7);
        chk("lk_mem8", mem[10'h0C8], 32'd8);
        chk("lk_mem19", mem[10'h0D3], 32'd19);
        @(negedge clk);
        chk("lk_end_state", dut.state_q, ST_IDLE);

        // Lock dropped mid-burst with both requesting.
        d_m1  = 6'b101111;
        d_m0r = 6'b011110;
        d_lk  = 6'b000111;
        for (int c = 0; c < 6; c++) begin
            m1_req = 1; m1_we = 1; m1_addr = 32'h400;
            m1_wdata = 32'hA5A50000;
            m1_lock = d_lk[c];
            m0_req = d_m0r[c];
            m0_addr = 32'h100;
            #1;
            chk("dr_m1_gnt", m1_gnt, d_m1[c]);
            chk("dr_m0_gnt", m0_gnt, !d_m1[c]);
            if (c == 4) begin
                chk("dr_state", dut.state_q, ST_IDLE);
                chk("dr_cnt", 32'(dut.lock_cnt_q), 0);
            end
            @(negedge clk);
        end
        idle();

        // Reset during an m0 store with m1 rvalid pending.
        m1_req = 1; m1_addr = 32'h200;
        #1;
        chk("rm_m1_gnt", m1_gnt, 1);
        @(negedge clk);
        idle();
        m0_req = 1; m0_we = 1; m0_addr = 32'h100;
        m0_wdata = 32'hCAFEF00D;
        #1;
        chk("rm_pre_rvalid", m1_rvalid, 1);
        chk("rm_pre_memwrite", memwrite, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rm_memwrite", memwrite, 0);
        chk("rm_m0_gnt", m0_gnt, 0);
        chk("rm_m1_rvalid", m1_rvalid, 0);
        chk("rm_m1_rdata", m1_rdata, 0);
        @(negedge clk);
        chk("rm_mem_kept", mem[10'h040], 32'hDEADBEEF);
        reset = 1'b1;
        idle();
        m0_req = 1; m0_addr = 32'h100;
        m1_req = 1; m1_addr = 32'h200;
        #1;
        chk("post_rst_m0_gnt", m0_gnt, 1);
        chk("post_rst_m1_gnt", m1_gnt, 0);
        @(negedge clk);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
